// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared jump-type constants, prediction entry and FSM state types
package fetch_pkg;

  localparam logic [2:0] JALR = 3'd3;
  localparam logic [2:0] CALL = 3'd4;
  localparam logic [2:0] RET  = 3'd5;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  jtype;
    logic [2:0]  idx;
  } pred_entry_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    CORRECT = 2'd1,
    RECOVER = 2'd2
  } state_t;

endpackage

// File: rtl/pred_queue.sv
// rtl/pred_queue.sv - in-order circular queue of outstanding jump predictions
module pred_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  pred_entry_t push_data,
  input  logic        pop,
  input  logic        flush,
  output logic [CW-1:0] count,
  output pred_entry_t head
);

  pred_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage write; the caller never pushes in a flushing cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_redirect_gen.sv
// rtl/fetch_redirect_gen.sv - prediction check and fetch correction generator; optional MISPREDICT_CNT_EN adds a saturating mispredict counter
module fetch_redirect_gen
  import fetch_pkg::*;
#(
  parameter int QDEPTH         = 8,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic        i_fire,
  input  logic        rst,
  input  logic        i_predValid,
  input  logic [31:0] i_predPc_32,
  input  logic [2:0]  i_predType_3,
  input  logic [2:0]  i_btbIndex_3,
  output logic        o_predReady,
  input  logic        i_resValid,
  input  logic [31:0] i_resTarget_32,
  output logic [31:0] o_correctPc_32,
  output logic [2:0]  o_correctPcIndex_3,
  output logic        o_type,
  output logic        o_busy
`ifdef MISPREDICT_CNT_EN
  ,
  output logic [15:0] o_mispredCount_16
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  state_t      state, state_n;
  logic [RW-1:0] rec_cnt, rec_cnt_n;
  logic [31:0] cpc_n;
  logic [2:0]  cidx_n;
  logic        ctype_n;
  logic        push, pop, flush, mispredict, not_full;
  logic [CW-1:0] count;
  pred_entry_t head;
  pred_entry_t new_entry;

  assign not_full  = (count < CW'(QDEPTH));
  assign new_entry = '{pc: i_predPc_32, jtype: i_predType_3, idx: i_btbIndex_3};

  pred_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (i_fire),
    .rst       (rst),
    .push      (push),
    .push_data (new_entry),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

  // Next-state, queue control and next correction values; corrections last one cycle.
  always_comb begin
    state_n    = state;
    rec_cnt_n  = rec_cnt;
    cpc_n      = '0;
    cidx_n     = '0;
    ctype_n    = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    mispredict = 1'b0;
    case (state)
      RUN: begin
        if (i_resValid && count != '0) begin
          if (head.pc == i_resTarget_32) begin
            pop = 1'b1;
          end else begin
            mispredict = 1'b1;
            flush      = 1'b1;
            cpc_n      = i_resTarget_32;
            cidx_n     = head.idx;
            ctype_n    = (head.jtype != JALR);
            state_n    = CORRECT;
          end
        end
        // A full queue still takes a new entry when the head leaves this cycle.
        push = i_predValid && !mispredict && (not_full || pop);
      end
      CORRECT: begin
        state_n   = RECOVER;
        rec_cnt_n = RW'(RECOVER_CYCLES - 1);
      end
      RECOVER: begin
        if (rec_cnt == '0) state_n = RUN;
        else               rec_cnt_n = rec_cnt - RW'(1);
      end
      default: state_n = RUN;
    endcase
  end

  // State, recovery counter and registered correction outputs.
  always_ff @(posedge i_fire or negedge rst) begin
    if (!rst) begin
      state              <= RUN;
      rec_cnt            <= '0;
      o_correctPc_32     <= '0;
      o_correctPcIndex_3 <= '0;
      o_type             <= 1'b0;
    end else begin
      state              <= state_n;
      rec_cnt            <= rec_cnt_n;
      o_correctPc_32     <= cpc_n;
      o_correctPcIndex_3 <= cidx_n;
      o_type             <= ctype_n;
    end
  end

  assign o_busy      = (state != RUN);
  assign o_predReady = (state == RUN) && not_full;

`ifdef MISPREDICT_CNT_EN
  // Saturating count of RUN->CORRECT transitions.
  always_ff @(posedge i_fire or negedge rst) begin
    if (!rst)                                        o_mispredCount_16 <= '0;
    else if (mispredict && o_mispredCount_16 != 16'hFFFF) o_mispredCount_16 <= o_mispredCount_16 + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_gen.sv
// tb/tb_fetch_redirect_gen.sv - scoreboard bench for fetch_redirect_gen (MISPREDICT_CNT_EN optional)
module tb_fetch_redirect_gen;
  import fetch_pkg::*;

  localparam int QD = 8;
  localparam int RC = 2;

  logic        i_fire = 1'b0;
  logic        rst    = 1'b0;
  logic        i_predValid = 1'b0;
  logic [31:0] i_predPc_32 = '0;
  logic [2:0]  i_predType_3 = '0;
  logic [2:0]  i_btbIndex_3 = '0;
  logic        o_predReady;
  logic        i_resValid = 1'b0;
  logic [31:0] i_resTarget_32 = '0;
  logic [31:0] o_correctPc_32;
  logic [2:0]  o_correctPcIndex_3;
  logic        o_type;
  logic        o_busy;
`ifdef MISPREDICT_CNT_EN
  logic [15:0] o_mispredCount_16;
`endif

  fetch_redirect_gen #(.QDEPTH(QD), .RECOVER_CYCLES(RC)) dut (
    .i_fire             (i_fire),
    .rst                (rst),
    .i_predValid        (i_predValid),
    .i_predPc_32        (i_predPc_32),
    .i_predType_3       (i_predType_3),
    .i_btbIndex_3       (i_btbIndex_3),
    .o_predReady        (o_predReady),
    .i_resValid         (i_resValid),
    .i_resTarget_32     (i_resTarget_32),
    .o_correctPc_32     (o_correctPc_32),
    .o_correctPcIndex_3 (o_correctPcIndex_3),
    .o_type             (o_type),
    .o_busy             (o_busy)
`ifdef MISPREDICT_CNT_EN
    ,
    .o_mispredCount_16  (o_mispredCount_16)
`endif
  );

  always #5 i_fire = ~i_fire;

  typedef struct {
    logic [31:0] cpc;
    logic [2:0]  idx;
    logic        typ;
    logic        busy;
    logic        ready;
  } exp_t;

  exp_t        sb[$];
  pred_entry_t mq[$];
  state_t      mstate = RUN;
  int          mrec = 0;
  int          mcnt = 0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    mstate = RUN;
    mrec = 0;
  endtask

  // Drive one cycle, predict the post-edge outputs, then compare after the edge.
  task automatic step(input bit pv, input logic [31:0] ppc, input logic [2:0] pt,
                      input logic [2:0] pi, input bit rv, input logic [31:0] rt);
    exp_t e, g;
    bit   popped, mis;
    pred_entry_t ne;
    i_predValid = pv; i_predPc_32 = ppc; i_predType_3 = pt; i_btbIndex_3 = pi;
    i_resValid = rv;  i_resTarget_32 = rt;
    e = '{cpc: 32'h0, idx: 3'h0, typ: 1'b0, busy: 1'b0, ready: 1'b0};
    popped = 0; mis = 0;
    case (mstate)
      RUN: begin
        if (rv && mq.size() > 0) begin
          if (mq[0].pc == rt) popped = 1;
          else begin
            mis = 1;
            e.cpc = rt; e.idx = mq[0].idx; e.typ = (mq[0].jtype != 3'd3);
          end
        end
        if (mis) begin
          mq.delete();
          mstate = CORRECT;
          if (mcnt < 16'hFFFF) mcnt++;
        end else begin
          if (popped) void'(mq.pop_front());
          if (pv && mq.size() < QD) begin
            ne.pc = ppc; ne.jtype = pt; ne.idx = pi;
            mq.push_back(ne);
          end
        end
      end
      CORRECT: begin mstate = RECOVER; mrec = RC - 1; end
      default: begin if (mrec == 0) mstate = RUN; else mrec--; end
    endcase
    e.busy  = (mstate != RUN);
    e.ready = (mstate == RUN) && (mq.size() < QD);
    sb.push_back(e);
    @(posedge i_fire); #1;
    g = sb.pop_front();
    check("correct_pc", o_correctPc_32, g.cpc);
    check("correct_idx", 32'(o_correctPcIndex_3), 32'(g.idx));
    check("type", 32'(o_type), 32'(g.typ));
    check("busy", 32'(o_busy), 32'(g.busy));
    check("pred_ready", 32'(o_predReady), 32'(g.ready));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 32'h0, 3'd0, 3'd0, 0, 32'h0);
  endtask

  // Assert reset between edges and check outputs respond without a clock edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    check({tag, "_rst_pc"}, o_correctPc_32, 32'h0);
    check({tag, "_rst_busy"}, 32'(o_busy), 32'h0);
    check({tag, "_rst_ready"}, 32'(o_predReady), 32'h1);
    model_reset();
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [31:0] t;
    // power-on reset
    repeat (2) @(posedge i_fire);
    #1;
    check("reset_pc", o_correctPc_32, 32'h0);
    check("reset_idx", 32'(o_correctPcIndex_3), 32'h0);
    check("reset_type", 32'(o_type), 32'h0);
    check("reset_busy", 32'(o_busy), 32'h0);
    check("reset_ready", 32'(o_predReady), 32'h1);
    rst = 1'b1;
    idle(2);
    async_reset("idle");
    idle(1);

    // match path
    step(1, 32'h100, 3'd4, 3'd0, 0, 32'h0);
    step(0, 32'h0, 3'd0, 3'd0, 1, 32'h100);
    check("match_no_corr", o_correctPc_32, 32'h0);
    step(0, 32'h0, 3'd0, 3'd0, 1, 32'h100);

    // JALR mispredict, enqueues during recovery are dropped
    step(1, 32'h200, 3'd3, 3'd5, 0, 32'h0);
    step(0, 32'h0, 3'd0, 3'd0, 1, 32'h240);
    check("jalr_pc", o_correctPc_32, 32'h240);
    check("jalr_idx", 32'(o_correctPcIndex_3), 32'd5);
    check("jalr_type", 32'(o_type), 32'd0);
    for (int k = 0; k < RC + 1; k++) step(1, 32'h300, 3'd3, 3'd1, 0, 32'h0);
    step(0, 32'h0, 3'd0, 3'd0, 1, 32'h300);
    check("dropped_no_corr", o_correctPc_32, 32'h0);

    // RET mispredict with 3 queued and a same-cycle enqueue
    step(1, 32'h10, 3'd5, 3'd1, 0, 32'h0);
    step(1, 32'h20, 3'd1, 3'd2, 0, 32'h0);
    step(1, 32'h30, 3'd4, 3'd3, 0, 32'h0);
    step(1, 32'h999, 3'd0, 3'd7, 1, 32'h11);
    check("ret_type", 32'(o_type), 32'd1);
    check("ret_pc", o_correctPc_32, 32'h11);
    idle(RC + 1);
    step(1, 32'h40, 3'd0, 3'd0, 0, 32'h0);
    step(0, 32'h0, 3'd0, 3'd0, 1, 32'h40);
    check("no_leak_pc", o_correctPc_32, 32'h0);

    // full queue, pop-then-push, order across wrap
    for (int k = 0; k < QD; k++) step(1, 32'h1000 + 32'(k), 3'd0, 3'(k), 0, 32'h0);
    check("full_ready", 32'(o_predReady), 32'h0);
    step(1, 32'h2000, 3'd0, 3'd0, 1, 32'h1000);
    check("full_swap_ready", 32'(o_predReady), 32'h0);
    step(1, 32'h3000, 3'd0, 3'd0, 0, 32'h0);
    for (int k = 1; k < QD; k++) step(0, 32'h0, 3'd0, 3'd0, 1, 32'h1000 + 32'(k));
    step(0, 32'h0, 3'd0, 3'd0, 1, 32'h2000);
    check("wrap_order_pc", o_correctPc_32, 32'h0);
    step(0, 32'h0, 3'd0, 3'd0, 1, 32'h1234);
    idle(2);

    // empty-queue resolve ignored
    step(0, 32'h0, 3'd0, 3'd0, 1, 32'h5555);

    // reset mid-CORRECT and mid-RECOVER
    step(1, 32'h700, 3'd3, 3'd2, 0, 32'h0);
    step(0, 32'h0, 3'd0, 3'd0, 1, 32'h704);
    async_reset("correct");
    step(1, 32'h800, 3'd3, 3'd2, 0, 32'h0);
    step(0, 32'h0, 3'd0, 3'd0, 1, 32'h804);
    idle(1);
    async_reset("recover");
    idle(1);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      if (mq.size() > 0 && $urandom_range(3) != 0) t = mq[0].pc;
      else t = $urandom | 32'h1;
      step(bit'($urandom_range(1)), $urandom | 32'h1, 3'($urandom_range(7)),
           3'($urandom_range(7)), bit'($urandom_range(1)), t);
    end

`ifdef MISPREDICT_CNT_EN
    check("mispred_count", 32'(o_mispredCount_16), 32'(mcnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_gen.md
Name: fetch_redirect_gen

Overview:
- Backend-side producer of the fetch correction interface: `i_correctPc_32`, `i_correctPcIndex_3` and `i_type` as consumed by the next-PC/RAS/JALR-BTB stage.
- Records each frontend jump prediction in an in-order queue and compares it against the target resolved in execute.
- On mismatch, emits a one-cycle correction, flushes the queue, then blanks wrong-path traffic for a fixed recovery window.

Parameters:
- QDEPTH, 8, prediction-queue entries (power of 2, ≥2).
- RECOVER_CYCLES, 2, cycles after a correction during which enqueue and resolve are ignored (≥1).

Ports:
- i_fire  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- i_predValid  in  1  frontend issued a jump prediction this cycle.
- i_predPc_32  in  32  predicted next PC.
- i_predType_3  in  3  jump type: JALR=3, CALL=4, RET=5, others=direct.
- i_btbIndex_3  in  3  JALR-BTB index used for the prediction.
- o_predReady  out  1  queue can accept; enqueue = i_predValid & o_predReady.
- i_resValid  in  1  execute resolved the oldest outstanding jump.
- i_resTarget_32  in  32  actual target (never 0).
- o_correctPc_32  out  32  correct PC; 0 = no error this cycle.
- o_correctPcIndex_3  out  3  BTB index to update.
- o_type  out  1  1 = do not update BTB (non-JALR), 0 = update BTB.
- o_busy  out  1  state ≠ RUN.

Behaviour:
- Reset (async, rst=0):
  - Queue empty; pointers and count 0; state RUN.
  - o_correctPc_32=0, o_correctPcIndex_3=0, o_type=0, o_busy=0, o_predReady=1.
- Queue:
  - Circular FIFO of {pc, type, idx}; count width $clog2(QDEPTH)+1; pointers wrap modulo QDEPTH.
  - o_predReady = (state==RUN) & (count<QDEPTH).
  - A full queue still accepts an enqueue in a cycle that pops (pop-then-push); count unchanged.
- RUN state, per edge:
  - i_resValid with count==0: ignored (no pop, no correction).
  - i_resValid with count>0 and head.pc == i_resTarget_32: pop; outputs stay 0.
  - i_resValid with count>0 and head.pc != i_resTarget_32 (mispredict):
    - register o_correctPc_32 = i_resTarget_32, o_correctPcIndex_3 = head.idx, o_type = (head.type != JALR).
    - flush the queue (pointers and count to 0); any same-cycle enqueue is discarded.
    - go to CORRECT.
  - Enqueue and matching pop in the same cycle: both occur.
- CORRECT (exactly 1 cycle):
  - Correction outputs valid this cycle (latency 1 edge from the resolving edge).
  - At the next edge, outputs clear to 0, recovery counter loads RECOVER_CYCLES-1, state goes to RECOVER.
- RECOVER:
  - i_predValid and i_resValid ignored; o_predReady=0.
  - Counter decrements each edge; at 0, state returns to RUN.
- o_busy = 1 in CORRECT and RECOVER.
- States: RUN→CORRECT on mispredict; CORRECT→RECOVER always; RECOVER→RUN when counter==0.
- Reset mid-CORRECT or mid-RECOVER: immediate return to reset values; any pending correction is dropped.
- Arithmetic: compare is a full 32-bit equality; no other arithmetic on PCs.

Optional Feature:
- Macro MISPREDICT_CNT_EN.
- Defined:
  - adds output o_mispredCount_16 (16 bits), a saturating count of mispredicts.
  - increments on each RUN→CORRECT transition; holds at 16'hFFFF; reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package fetch_pkg:
  - jump-type constants JALR=3'd3, CALL=3'd4, RET=3'd5.
  - prediction-entry struct {pc[31:0], type[2:0], idx[2:0]}.
  - state enum RUN/CORRECT/RECOVER.
- One sub-module: pred_queue.
  - Parameterised FIFO with push/pop/flush, count, head outputs.
  - fetch_redirect_gen holds the FSM, compare and output registers.

Test Plan:
- Reset then idle: rst low mid-cycle → all outputs 0, o_predReady=1 asynchronously.
- Match path: enqueue pc=0x100 type=4, then resolve target=0x100 → no correction, count 1→0, o_correctPc_32 stays 0.
- JALR mispredict: enqueue pc=0x200 type=3 idx=5, resolve 0x240 → next cycle only o_correctPc_32=0x240, idx=5, o_type=0. Then o_busy=1 and o_predReady=0 for RECOVER_CYCLES cycles; enqueues in that window are dropped.
- RET mispredict with 3 queued entries and a same-cycle enqueue → o_type=1, queue empty after, the enqueued entry does not appear later.
- Full queue: 8 enqueues → o_predReady=0. Resolve-match plus enqueue in the same cycle → count stays 8, FIFO order preserved across pointer wrap.
- Resolve with empty queue → no change. With MISPREDICT_CNT_EN, 3 mispredicts → o_mispredCount_16=3; preloading via forced 0xFFFF followed by a mispredict → stays 0xFFFF.
